pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 29 ++
 rtl/pipe_skid_reg_flopenrc_n.sv | 25 ++
 rtl/pipe_skid_reg.sv | 98 +++++++++
 tb/tb_pipe_skid_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared state encodings and decode helpers for the two-entry skid register stage.
// The `SKID_ST_* constants are the single source for state encodings.
`ifndef PIPE_SKID_REG_DEFS
`define PIPE_SKID_REG_DEFS
`define SKID_ST_EMPTY 2'b00
`define SKID_ST_ONE   2'b01
`define SKID_ST_FULL  2'b10
`endif

package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = `SKID_ST_EMPTY,
    ST_ONE   = `SKID_ST_ONE,
    ST_FULL  = `SKID_ST_FULL
  } skid_state_e;

  function automatic logic [1:0] count_of(input skid_state_e st);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (st)
      ST_ONE:  cnt = 2'd1;
      ST_FULL: cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_flopenrc_n.sv
// Enable/clear data flop with active-low asynchronous reset.
// Synchronous clear takes priority over enable.
module flopenrc_n #(
  parameter int unsigned         WIDTH     = 32,
  parameter logic [WIDTH-1:0]    CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CLEAR_VAL;
    end else if (clr) begin
      q <= CLEAR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full-throughput valid/ready stage whose in_ready
// depends only on registered state, cutting the combinational ready path.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      state_q, state_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign count     = count_of(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    // flush wins; data registers are cleared through their clr input
    if (!flush) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  flopenrc_n #(.WIDTH(WIDTH), .CLEAR_VAL(CLEAR_VAL)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en    (main_en),
    .clr   (flush),
    .d     (main_d),
    .q     (main_q)
  );

  flopenrc_n #(.WIDTH(WIDTH), .CLEAR_VAL(CLEAR_VAL)) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .en    (skid_en),
    .clr   (flush),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus hand-written corner sequences and a randomized
// scoreboard run for the two-entry skid register.
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.WIDTH(32), .CLEAR_VAL(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] din;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_cnt;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic ir,
                            input logic [1:0] cnt, input logic [31:0] dout);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    check({tag, ".count"},     64'(count),     64'(cnt));
    check({tag, ".out_data"},  64'(out_data),  64'(dout));
  endtask

  logic [31:0] sb[$];
  logic        r_iv, r_or, r_inf, r_outf;
  logic [31:0] r_din;

  initial begin
    //            fl    iv    ordy  din           ov    ir    cnt   dout
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'd1,        1'b1, 1'b1, 2'd1, 32'd1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'd2,        1'b1, 1'b1, 2'd1, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd3,        1'b1, 1'b1, 2'd1, 32'd3};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd4,        1'b1, 1'b1, 2'd1, 32'd4};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 2'd0, 32'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hA1,       1'b1, 1'b1, 2'd1, 32'hA1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'hA2,       1'b1, 1'b0, 2'd2, 32'hA1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'hA3,       1'b1, 1'b0, 2'd2, 32'hA1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hA3,       1'b1, 1'b1, 2'd1, 32'hA2};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'hA3,       1'b1, 1'b1, 2'd1, 32'hA3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 2'd0, 32'hA3};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'hA4,       1'b1, 1'b1, 2'd1, 32'hA4};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'hB5,       1'b1, 1'b0, 2'd2, 32'hA4};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h55,       1'b0, 1'b1, 2'd0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h6,        1'b1, 1'b1, 2'd1, 32'h6};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h77,       1'b0, 1'b1, 2'd0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h9,        1'b1, 1'b1, 2'd1, 32'h9};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h10,       1'b1, 1'b0, 2'd2, 32'h9};

    // Reset held while upstream offers data
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    step();
    check_outs("reset", 1'b0, 1'b1, 2'd0, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      in_data   = vecs[i].din;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                 vecs[i].e_cnt, vecs[i].e_dout);
    end

    // FULL: in_ready must stay low even with out_ready high this cycle
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    out_ready = 1'b1;
    #1;
    check("full_ready_indep", 64'(in_ready), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Asynchronous reset mid-cycle while FULL
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b1, 2'd0, 32'h0);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h7;
    step();
    check_outs("post_rst", 1'b1, 1'b1, 2'd1, 32'h7);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_outs("drain", 1'b0, 1'b1, 2'd0, 32'h7);

    // Randomized valid/ready against a queue scoreboard
    sb.delete();
    for (int c = 0; c < 4000; c++) begin
      r_iv  = 1'($urandom_range(0, 1));
      r_or  = 1'($urandom_range(0, 1));
      r_din = $urandom();
      in_valid  = r_iv;
      out_ready = r_or;
      in_data   = r_din;
      check("rnd.count",    64'(count),     64'(sb.size()));
      check("rnd.in_ready", 64'(in_ready),  64'(sb.size() < 2));
      check("rnd.out_valid",64'(out_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) check("rnd.out_data", 64'(out_data), 64'(sb[0]));
      r_inf  = r_iv && (sb.size() < 2);
      r_outf = r_or && (sb.size() > 0);
      step();
      if (r_outf) void'(sb.pop_front());
      if (r_inf)  sb.push_back(r_din);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
